pipe_if: RTL and testbench
==========================

# pipe_if

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage. Holds the PC and selects the next PC from the redirect sources driven back by decode. Fetches from instruction memory over a req/ack handshake and drives the IF/ID pipeline register that decode consumes. Handles decode stalls, multi-cycle memory and redirects that arrive while a fetch is still pending.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word presented with a bubble (sll $0,$0,0).

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  synchronous reset, active-low.
- pcsrc  in  2  next-PC select from decode: 00 = pc+4, 01 = bpc, 10 = rpc, 11 = jpc.
- bpc  in  32  branch target.
- rpc  in  32  jr register target.
- jpc  in  32  jump target.
- wpcir  in  1  active-low stall from decode; 0 = hold PC and IF/ID.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_rdata  in  32  instruction word; valid when imem_ack = 1.
- imem_ack  in  1  fetch complete, same cycle as imem_req or later.
- if_inst  out  32  IF/ID instruction.
- if_pc4  out  32  IF/ID pc+4.
- if_valid  out  1  IF/ID holds a real instruction.

## Operation
- Handshake:
  - Once raised, imem_req and imem_addr hold until the cycle with imem_ack = 1.
  - imem_ack is ignored when imem_req = 0.
- FSM with two states:
  - REQ: imem_req = 1.
  - HOLD: imem_req = 0; the fetched word waits in a skid register.
- REQ, ack = 1, wpcir = 1:
  - IF/ID <= {imem_rdata, pc+4, valid = 1}.
  - pc <= npc.
  - Stay in REQ.
- REQ, ack = 1, wpcir = 0:
  - skid <= imem_rdata.
  - IF/ID and pc held.
  - Go to HOLD.
- REQ, ack = 0, wpcir = 1:
  - IF/ID <= bubble {NOP_INST, pc+4, valid = 0}.
  - pc held.
- REQ, ack = 0, wpcir = 0: everything held.
- HOLD, wpcir = 1:
  - IF/ID <= {skid, pc+4, 1}.
  - pc <= npc.
  - Go to REQ.
- HOLD, wpcir = 0: everything held.
- npc selection:
  - pcsrc = 00: pc+4.
  - pcsrc ≠ 00: the selected target.
  - A pending redirect takes priority over both.
- pcsrc is sampled only in cycles where wpcir = 1.
- Pending redirect:
  - If pcsrc ≠ 00 and wpcir = 1 but the fetch does not complete this cycle (no ack in REQ), latch redir_pc and set redir_valid.
  - The next completing fetch (the delay slot) uses redir_pc as npc and clears redir_valid.
  - A new pcsrc ≠ 00 arriving while redir_valid = 1 overwrites it. Decode never issues two branches without a delay slot, so this is defensive only.
- pc+4 arithmetic: 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Reset values: pc = RESET_PC, if_inst = NOP_INST, if_pc4 = 0, if_valid = 0, redir_valid = 0, state = REQ.
- imem_req = 0 in any cycle where resetn = 0.
- Reset mid-fetch abandons the outstanding request. The memory drops an unacknowledged request when req falls.

## Timing
- Zero-wait memory (ack in the request cycle) gives one instruction per clock.
- Latency is 1 cycle from ack to valid if_inst.
- Each extra wait cycle inserts exactly one bubble, unless decode is stalled.
- A redirect is visible on imem_addr the cycle after the delay slot is accepted.
- All outputs except imem_req and imem_addr are registered.
- imem_req and imem_addr decode from registered state only; no combinational path from any input.

## Configuration
- PIPE_IF_PERF_EN defined adds two output ports:
  - perf_fetch  out  32: counts IF/ID loads with valid = 1.
  - perf_stall  out  32: counts cycles with imem_req = 1 and imem_ack = 0.
  - Both counters reset to 0 and wrap modulo 2^32.
- PIPE_IF_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package: pcsrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JR, PCSRC_J), the FSM state type, RESET_PC and NOP_INST.
- One sub-module: mux4x32 for npc selection, a sibling of the existing mux2x32.
- Pending-redirect override and pc+4 stay inline.

## Test plan
- Reset, zero-wait memory, wpcir = 1 → imem_addr 0, 4, 8 on consecutive cycles; if_pc4 = 4, 8, 12; if_valid = 1 from cycle 2.
- Ack delayed 2 cycles at pc = 8 → two bubbles with if_inst = 0 and if_valid = 0; pc stays 8 until ack, then fetches 12.
- Ack at pc = 16 while wpcir = 0 for 3 cycles → FSM in HOLD, imem_req = 0, IF/ID unchanged; on wpcir = 1, if_inst = the skid word and imem_addr = 20.
- pcsrc = 01, bpc = 0x100 while the delay slot at pc = 24 waits 2 cycles → delay slot delivered with if_pc4 = 28; next imem_addr = 0x100.
- pc = 0xFFFF_FFFC fetch → if_pc4 = 0; next imem_addr = 0.
- resetn low mid-wait at pc = 40 → next cycle imem_req = 1, imem_addr = RESET_PC, if_valid = 0; with PIPE_IF_PERF_EN, perf_fetch = 0.

Source files
------------

// File: rtl/pipe_if_pkg.sv
//============================================================================
// Module  : pipe_if_pkg
// Brief   : Shared encodings and reset constants for the instruction-fetch stage.
// Revision: 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package pipe_if_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pcsrc_e;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_if_if.sv
//============================================================================
// Module  : pipe_if_if
// Brief   : Fetch-stage bus: decode redirect/stall inputs, imem handshake, IF/ID.
// Revision: 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pipe_if_if;
    logic [1:0]  pcsrc;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        wpcir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        if_valid;

    modport master (
        input  pcsrc, bpc, rpc, jpc, wpcir, imem_rdata, imem_ack,
        output imem_req, imem_addr, if_inst, if_pc4, if_valid
    );

    modport slave (
        output pcsrc, bpc, rpc, jpc, wpcir, imem_rdata, imem_ack,
        input  imem_req, imem_addr, if_inst, if_pc4, if_valid
    );
endinterface

`default_nettype wire

// File: rtl/pipe_if_mux4x32.sv
//============================================================================
// Module  : mux4x32
// Brief   : 4-way 32-bit next-PC selector indexed by the pcsrc encoding.
// Revision: 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module mux4x32
    import pipe_if_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    output logic [31:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            PCSRC_BR: y = d1;
            PCSRC_JR: y = d2;
            PCSRC_J:  y = d3;
            default:  y = d0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pipe_if.sv
//============================================================================
// Module  : pipe_if
// Brief   : Instruction-fetch stage: PC, req/ack imem fetch, skid, IF/ID register.
//           Optional perf counters when PIPE_IF_PERF_EN is defined.
// Revision: 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_if
    import pipe_if_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    pipe_if_if.master   bus
`ifdef PIPE_IF_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_q, skid_d;
    logic [31:0]  redir_pc_q, redir_pc_d;
    logic         redir_valid_q, redir_valid_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic [31:0]  if_pc4_q, if_pc4_d;
    logic         if_valid_q, if_valid_d;

    logic [31:0]  pc4;
    logic [31:0]  target;
    logic [31:0]  npc;
    logic         redirect;
    logic         accept;
    logic         imem_req;

    assign pc4      = pc_q + 32'd4;
    assign redirect = bus.wpcir && (bus.pcsrc != PCSRC_SEQ);
    // A redirect captured while the delay slot was still in flight wins.
    assign npc      = redir_valid_q ? redir_pc_q : target;

    mux4x32 u_npc_mux (
        .sel (bus.pcsrc),
        .d0  (pc4),
        .d1  (bus.bpc),
        .d2  (bus.rpc),
        .d3  (bus.jpc),
        .y   (target)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_d        = skid_q;
        redir_pc_d    = redir_pc_q;
        redir_valid_d = redir_valid_q;
        if_inst_d     = if_inst_q;
        if_pc4_d      = if_pc4_q;
        if_valid_d    = if_valid_q;
        accept        = 1'b0;

        case (state_q)
            S_REQ: begin
                if (bus.imem_ack) begin
                    if (bus.wpcir) begin
                        accept = 1'b1;
                    end else begin
                        skid_d  = bus.imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (bus.wpcir) begin
                    if_inst_d  = NOP_INST;
                    if_pc4_d   = pc4;
                    if_valid_d = 1'b0;
                    if (redirect) begin
                        redir_pc_d    = target;
                        redir_valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (bus.wpcir) begin
                    accept  = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (accept) begin
            if_inst_d     = (state_q == S_HOLD) ? skid_q : bus.imem_rdata;
            if_pc4_d      = pc4;
            if_valid_d    = 1'b1;
            pc_d          = npc;
            redir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            skid_q        <= NOP_INST;
            redir_pc_q    <= RESET_PC;
            redir_valid_q <= 1'b0;
            if_inst_q     <= NOP_INST;
            if_pc4_q      <= 32'd0;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            skid_q        <= skid_d;
            redir_pc_q    <= redir_pc_d;
            redir_valid_q <= redir_valid_d;
            if_inst_q     <= if_inst_d;
            if_pc4_q      <= if_pc4_d;
            if_valid_q    <= if_valid_d;
        end
    end

    // Dropping req during reset is what abandons an outstanding fetch.
    assign imem_req      = resetn && (state_q == S_REQ);
    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = pc_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.if_pc4    = if_pc4_q;
    assign bus.if_valid  = if_valid_q;

`ifdef PIPE_IF_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (accept) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (imem_req && !bus.imem_ack) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_if.sv
//============================================================================
// Module  : tb_pipe_if
// Brief   : Directed scoreboard bench for the pipe_if fetch stage.
// Revision: 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_if;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    pipe_if_if bus ();

`ifdef PIPE_IF_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    pipe_if dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus)
`ifdef PIPE_IF_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic ld_q  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc4);
        exp_t e;
        e.inst = inst;
        e.pc4  = pc4;
        exp_q.push_back(e);
    endtask

    task automatic expect_out(input logic req, input logic [31:0] addr, input logic v);
        chk("imem_req", 32'(bus.imem_req), 32'(req));
        chk("imem_addr", bus.imem_addr, addr);
        chk("if_valid", 32'(bus.if_valid), 32'(v));
    endtask

    task automatic obs(input logic req, input logic [31:0] addr, input logic v);
        @(negedge clock);
        expect_out(req, addr, v);
    endtask

    task automatic drv(input logic ack, input logic [31:0] data, input logic wp, input logic [1:0] src);
        bus.imem_ack   = ack;
        bus.imem_rdata = data;
        bus.wpcir      = wp;
        bus.pcsrc      = src;
    endtask

    // IF/ID is consumed by decode whenever wpcir was high at the capturing edge.
    always @(posedge clock) ld_q <= bus.wpcir && resetn;

    always @(negedge clock) begin
        if (ld_q) begin
            if (bus.if_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ifid: got inst=%h pc4=%h, required no load", bus.if_inst, bus.if_pc4);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ifid_inst", bus.if_inst, e.inst);
                    chk("ifid_pc4", bus.if_pc4, e.pc4);
                end
            end else begin
                chk("bubble_inst", bus.if_inst, 32'h0000_0000);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.bpc = 32'h0000_0100;
        bus.rpc = 32'h0000_0028;
        bus.jpc = 32'hFFFF_FFFC;
        drv(1'b0, 32'h0, 1'b1, 2'b00);

        @(negedge clock);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        @(negedge clock);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_inst", bus.if_inst, 32'h0000_0000);
        chk("rst_pc4", bus.if_pc4, 32'h0000_0000);
        resetn = 1'b1;
        #1;
        expect_out(1'b1, 32'h0, 1'b0);

        // Zero-wait sequential fetch
        drv(1'b1, 32'h1111_0000, 1'b1, 2'b00); push(32'h1111_0000, 32'd4);
        obs(1'b1, 32'd4, 1'b1);  drv(1'b1, 32'h1111_0004, 1'b1, 2'b00); push(32'h1111_0004, 32'd8);
        // Two wait cycles at pc=8
        obs(1'b1, 32'd8, 1'b1);  drv(1'b0, 32'hBAD0_0000, 1'b1, 2'b00);
        obs(1'b1, 32'd8, 1'b0);  drv(1'b0, 32'hBAD0_0000, 1'b1, 2'b00);
        obs(1'b1, 32'd8, 1'b0);  drv(1'b1, 32'h1111_0008, 1'b1, 2'b00); push(32'h1111_0008, 32'd12);
        obs(1'b1, 32'd12, 1'b1); drv(1'b1, 32'h1111_000C, 1'b1, 2'b00); push(32'h1111_000C, 32'd16);
        // Ack at pc=16 under a 3-cycle decode stall
        obs(1'b1, 32'd16, 1'b1); drv(1'b1, 32'h1111_0010, 1'b0, 2'b00); push(32'h1111_0010, 32'd20);
        obs(1'b0, 32'd16, 1'b1); drv(1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00);
        obs(1'b0, 32'd16, 1'b1); drv(1'b0, 32'hDEAD_BEEF, 1'b0, 2'b00);
        obs(1'b0, 32'd16, 1'b1);
        chk("hold_inst", bus.if_inst, 32'h1111_000C);
        chk("hold_pc4", bus.if_pc4, 32'd16);
        drv(1'b0, 32'hDEAD_BEEF, 1'b1, 2'b00);
        obs(1'b1, 32'd20, 1'b1); drv(1'b1, 32'h1111_0014, 1'b1, 2'b00); push(32'h1111_0014, 32'd24);
        // Branch taken while the delay slot at pc=24 waits two cycles
        obs(1'b1, 32'd24, 1'b1); drv(1'b0, 32'hBAD0_0000, 1'b1, 2'b01);
        obs(1'b1, 32'd24, 1'b0); drv(1'b0, 32'hBAD0_0000, 1'b1, 2'b00);
        obs(1'b1, 32'd24, 1'b0); drv(1'b1, 32'h1111_0018, 1'b1, 2'b00); push(32'h1111_0018, 32'd28);
        // Jump to the top of the address space, then wrap
        obs(1'b1, 32'h100, 1'b1); drv(1'b1, 32'h2222_0100, 1'b1, 2'b11); push(32'h2222_0100, 32'h104);
        obs(1'b1, 32'hFFFF_FFFC, 1'b1); drv(1'b1, 32'h3333_FFFC, 1'b1, 2'b00); push(32'h3333_FFFC, 32'd0);
        obs(1'b1, 32'd0, 1'b1);  drv(1'b1, 32'h4444_0000, 1'b1, 2'b10); push(32'h4444_0000, 32'd4);
        obs(1'b1, 32'd40, 1'b1);
`ifdef PIPE_IF_PERF_EN
        chk("perf_fetch", perf_fetch, 32'd10);
        chk("perf_stall", perf_stall, 32'd4);
`endif
        drv(1'b0, 32'hBAD0_0000, 1'b1, 2'b00);
        // Reset asserted mid-wait at pc=40
        obs(1'b1, 32'd40, 1'b0);
        resetn = 1'b0;
        #1;
        chk("rst_mid_req", 32'(bus.imem_req), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        expect_out(1'b1, 32'h0, 1'b0);
        chk("rst_mid_inst", bus.if_inst, 32'h0000_0000);
        chk("rst_mid_pc4", bus.if_pc4, 32'h0000_0000);
`ifdef PIPE_IF_PERF_EN
        chk("rst_perf_fetch", perf_fetch, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
`endif
        drv(1'b1, 32'h5555_0000, 1'b1, 2'b00); push(32'h5555_0000, 32'd4);
        obs(1'b1, 32'd4, 1'b1);  drv(1'b0, 32'hBAD0_0000, 1'b1, 2'b00);
        obs(1'b1, 32'd4, 1'b0);
        @(negedge clock);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
